// File: rtl/hsi_mse_lib_seq.sv
// Library-scan sequencer for the two-channel MSE datapath: streams every library vector
// against one pixel and keeps the best match. Optional macro: HSI_MSE_SEQ_THRESHOLD_EN.
module hsi_mse_lib_seq #(
  parameter int WORD_WIDTH       = 32,
  parameter int DATA_WIDTH       = 16,
  parameter int HSI_BANDS        = 128,
  parameter int HSI_LIBRARY_SIZE = 256,
  localparam int WORDS           = HSI_BANDS / 2,
  localparam int WORDS_ADDR      = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int LIB_ADDR        = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [LIB_ADDR:0]              cfg_lib_size,
  output logic [WORDS_ADDR-1:0]          pix_addr,
  input  logic [WORD_WIDTH-1:0]          pix_data,
  output logic [LIB_ADDR+WORDS_ADDR-1:0] lib_addr,
  input  logic [WORD_WIDTH-1:0]          lib_data,
  output logic                           element_start,
  output logic                           element_last,
  output logic [LIB_ADDR-1:0]            vctr_ref,
  output logic [WORD_WIDTH-1:0]          element_a,
  output logic [WORD_WIDTH-1:0]          element_b,
  output logic                           element_valid,
  input  logic [WORD_WIDTH-1:0]          mse_value,
  input  logic [LIB_ADDR-1:0]            mse_ref,
  input  logic                           mse_valid,
  output logic                           busy,
  output logic                           done,
  output logic [LIB_ADDR-1:0]            best_ref,
  output logic [WORD_WIDTH-1:0]          best_mse,
`ifdef HSI_MSE_SEQ_THRESHOLD_EN
  input  logic [WORD_WIDTH-1:0]          mse_threshold,
  output logic                           match_found,
`endif
  output logic [1:0]                     dbg_state
);

  localparam int LA_W  = LIB_ADDR + WORDS_ADDR;
  localparam int CNT_W = LIB_ADDR + 1;
  localparam logic [WORDS_ADDR-1:0] WORD_LAST = WORDS_ADDR'(WORDS - 1);
  localparam logic [CNT_W-1:0]      LIB_MAX   = CNT_W'(HSI_LIBRARY_SIZE);

  if (WORD_WIDTH != 2 * DATA_WIDTH || HSI_BANDS < 2 || (HSI_BANDS % 2) != 0) begin : g_bad_cfg
    $error("hsi_mse_lib_seq: WORD_WIDTH must be 2*DATA_WIDTH and HSI_BANDS even and >= 2");
  end

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                  state;
  logic [WORDS_ADDR-1:0]   word;
  logic [LIB_ADDR-1:0]     vec;
  logic [LIB_ADDR-1:0]     vec_last;
  logic [CNT_W-1:0]        target;
  logic [CNT_W-1:0]        res_cnt;
  logic [CNT_W-1:0]        res_cnt_nxt;
  logic [CNT_W-1:0]        size_clamped;
  logic                    collecting;
  logic                    res_inc;
  logic                    upd;
  logic                    stop;

  assign collecting   = (state == FEED) || (state == DRAIN);
  assign res_inc      = collecting && mse_valid;
  assign res_cnt_nxt  = res_cnt + CNT_W'(res_inc);
  assign upd          = res_inc && (mse_value < best_mse);
  assign size_clamped = (cfg_lib_size > LIB_MAX) ? LIB_MAX : cfg_lib_size;

`ifdef HSI_MSE_SEQ_THRESHOLD_EN
  logic [WORD_WIDTH-1:0] thr;
  logic                  hit;
  logic                  hit_now;
  logic [WORD_WIDTH-1:0] best_mse_nxt;

  assign hit_now      = res_inc && (mse_value <= thr);
  assign best_mse_nxt = upd ? mse_value : best_mse;
  // A hit only stops issue at a vector boundary so the datapath never sees a partial vector.
  assign stop         = (vec == vec_last) || hit || hit_now;
`else
  assign stop         = (vec == vec_last);
`endif

  assign pix_addr  = word;
  assign lib_addr  = LA_W'(vec) * LA_W'(WORDS) + LA_W'(word);
  assign element_a = element_valid ? pix_data : '0;
  assign element_b = element_valid ? lib_data : '0;
  assign busy      = collecting;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      word          <= '0;
      vec           <= '0;
      vec_last      <= '0;
      target        <= '0;
      res_cnt       <= '0;
      element_valid <= 1'b0;
      element_start <= 1'b0;
      element_last  <= 1'b0;
      vctr_ref      <= '0;
      done          <= 1'b0;
      best_ref      <= '0;
      best_mse      <= '1;
`ifdef HSI_MSE_SEQ_THRESHOLD_EN
      thr           <= '0;
      hit           <= 1'b0;
      match_found   <= 1'b0;
`endif
    end else begin
      // Address-stage tags delayed one cycle to line up with the memory read data.
      element_valid <= (state == FEED);
      element_start <= (state == FEED) && (word == '0);
      element_last  <= (state == FEED) && (word == WORD_LAST);
      vctr_ref      <= (state == FEED) ? vec : '0;
      done          <= 1'b0;

      if (collecting) res_cnt <= res_cnt_nxt;
      if (upd) begin
        best_mse <= mse_value;
        best_ref <= mse_ref;
      end
`ifdef HSI_MSE_SEQ_THRESHOLD_EN
      if (hit_now) hit <= 1'b1;
`endif

      case (state)
        IDLE: begin
          if (start) begin
            best_mse <= '1;
            best_ref <= '0;
            word     <= '0;
            vec      <= '0;
            res_cnt  <= '0;
            target   <= size_clamped;
            vec_last <= LIB_ADDR'(size_clamped - CNT_W'(1));
`ifdef HSI_MSE_SEQ_THRESHOLD_EN
            thr         <= mse_threshold;
            hit         <= 1'b0;
            match_found <= 1'b0;
`endif
            if (cfg_lib_size == '0) begin
              state <= DONE;
              done  <= 1'b1;
`ifdef HSI_MSE_SEQ_THRESHOLD_EN
              match_found <= ('1 <= mse_threshold);
`endif
            end else begin
              state <= FEED;
            end
          end
        end
        FEED: begin
          if (word == WORD_LAST) begin
            word <= '0;
            if (stop) begin
              vec    <= '0;
              target <= CNT_W'(vec) + CNT_W'(1);
              state  <= DRAIN;
            end else begin
              vec <= vec + LIB_ADDR'(1);
            end
          end else begin
            word <= word + WORDS_ADDR'(1);
          end
        end
        DRAIN: begin
          if (res_cnt_nxt >= target) begin
            state <= DONE;
            done  <= 1'b1;
`ifdef HSI_MSE_SEQ_THRESHOLD_EN
            match_found <= (best_mse_nxt <= thr);
`endif
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hsi_mse_lib_seq.md
Name: hsi_mse_lib_seq

Overview:
Sequencer that drives the two-channel MSE datapath (hsi_mse_reg) across a spectral library. For one captured pixel, it streams every library vector against the pixel, one packed word per cycle, and collects the per-vector MSE results. It tracks the minimum MSE and its library index, then reports the best match. The block sits between the pixel/library memories and hsi_mse_reg, and is started by the top-level control.

Parameters:
- WORD_WIDTH, 32, memory/datapath word width; each word holds two DATA_WIDTH bands.
- DATA_WIDTH, 16, band sample width; WORD_WIDTH = 2*DATA_WIDTH.
- HSI_BANDS, 128, bands per vector; must be even and >= 2.
- HSI_LIBRARY_SIZE, 256, maximum library vectors.
- localparam WORDS = HSI_BANDS/2; WORDS_ADDR = max(1,$clog2(WORDS)); LIB_ADDR = $clog2(HSI_LIBRARY_SIZE).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a library scan (ignored while busy)
- cfg_lib_size  in  LIB_ADDR+1  number of vectors to scan; sampled on start
- pix_addr  out  WORDS_ADDR  pixel buffer word address
- pix_data  in  WORD_WIDTH  pixel word; valid 1 cycle after pix_addr
- lib_addr  out  LIB_ADDR+WORDS_ADDR  library address = ref*WORDS + word
- lib_data  in  WORD_WIDTH  library word; valid 1 cycle after lib_addr
- element_start, element_last  out  1  first/last word of the current vector
- vctr_ref  out  LIB_ADDR  library index of the current word
- element_a, element_b  out  WORD_WIDTH  pix_data, lib_data passthrough
- element_valid  out  1  element_* valid this cycle
- mse_value  in  WORD_WIDTH  datapath result
- mse_ref  in  LIB_ADDR  result index
- mse_valid  in  1  result strobe
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- best_ref  out  LIB_ADDR  index of the minimum MSE
- best_mse  out  WORD_WIDTH  minimum MSE value

Behaviour:
- Reset values: all outputs 0, except best_mse, which resets to all ones. The FSM resets to IDLE and all counters reset to 0.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - On start with cfg_lib_size == 0, go to DONE. best_ref = 0 and best_mse = all ones.
  - On start with cfg_lib_size > HSI_LIBRARY_SIZE, clamp the value to HSI_LIBRARY_SIZE.
  - On any other start, latch the size, set best_mse to all ones and best_ref to 0, clear the counters, and go to FEED.
- FEED:
  - Each cycle, issue pix_addr = word and lib_addr = ref*WORDS + word. word increments and wraps at WORDS-1, at which point ref increments.
  - After issuing ref = size-1, word = WORDS-1, go to DRAIN.
- Read alignment: the address-stage tags (valid, start = word==0, last = word==WORDS-1, ref) are registered one cycle to match the memory latency.
  - element_valid is therefore high exactly size*WORDS consecutive cycles, starting the cycle after FEED is entered.
  - With WORDS == 1, element_start and element_last are both high on every word.
- Result collection:
  - This runs in FEED and DRAIN. Each mse_valid increments the result count.
  - If mse_value < best_mse (strict), update best_mse and best_ref from mse_value and mse_ref. Ties keep the earlier (lower) ref.
  - mse_valid in IDLE or DONE is ignored.
- DRAIN: wait until the result count equals size, then go to DONE. There is no fixed datapath latency assumption.
- DONE: assert done for one cycle, then go to IDLE. busy is high in FEED and DRAIN only.
- best_ref and best_mse update live during a scan and are held from done until the next accepted start.
- start during FEED, DRAIN or DONE is ignored. start in the same cycle as done is also ignored, because the FSM is in DONE.
- Asynchronous reset mid-scan: immediate return to reset values. No done is issued.
- Address width: lib_addr is computed at full width (LIB_ADDR+WORDS_ADDR) with no truncation.

Optional Feature:
HSI_MSE_SEQ_THRESHOLD_EN
- When defined, the block adds two ports:
  - input mse_threshold (WORD_WIDTH)
  - output match_found (1)
- mse_threshold is sampled on start. match_found is 0 at reset and start, and is set on done if best_mse <= threshold. It is held with best_*.
- When a result with mse_value <= threshold arrives, FEED stops issuing new vectors after finishing the current vector (early terminate). The FSM goes to DRAIN and waits only for the results of vectors already issued.
- Without the macro, the ports are absent and every scan covers all vectors.

Test Plan:
1. HSI_BANDS=4, LIB=4, size=4, library MSEs {50,20,35,20} -> element_valid high 8 cycles; start/last alternate; done once; best_ref=1, best_mse=20 (tie keeps 1).
2. Reset mid-FEED at word 3 -> all outputs at reset values, best_mse=all ones, no done; a new start runs a clean full scan.
3. size=0 -> done 2 cycles after start, busy never high, best_mse=all ones, best_ref=0; size=9 with LIB=4 -> clamped, 4 vectors scanned.
4. Second start pulsed mid-scan -> ignored; exactly one done; lib_addr sequence 0..7 uninterrupted.
5. Datapath results delayed 10 cycles and mse_valid gapped -> DRAIN waits for all 4 results; done the cycle after the 4th result is counted.
6. (THRESHOLD_EN) threshold=25, MSEs {50,20,...} -> issue stops after vector 1 (plus any vector already in flight), match_found=1, best_ref=1.
